// File: rtl/hcsr04_interface_param.sv
// HC-SR04 rangefinder interface: trigger pulse, echo width in BCD centimetres, wait/echo timeouts.
// Define HCSR04_HOLD_LAST_EN to keep the last valid distance on timeout instead of loading all nines.
module hcsr04_interface_param #(
    parameter int TRIG_CLKS = 500,
    parameter int R         = 2941,
    parameter int DIGITS    = 3,
    parameter int WAIT_MAX  = 100000,
    parameter int ECHO_MAX  = 1500000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                medir,
    input  logic                echo,
    output logic                trigger,
    output logic                pronto,
    output logic                timeout,
    output logic [4*DIGITS-1:0] distancia,
    output logic [3:0]          db_estado
);

    localparam int TW = $clog2(TRIG_CLKS + 1);
    localparam int RW = $clog2(R + 1);
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam int EW = $clog2(ECHO_MAX + 1);
    localparam int BW = 4 * DIGITS;

    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CLKS - 1);
    localparam logic [RW-1:0] R_LAST    = RW'(R - 1);
    localparam logic [RW-1:0] R_HALF    = RW'(R / 2);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);
    localparam logic [EW-1:0] ECHO_LAST = EW'(ECHO_MAX - 1);
    localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'd9}};

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PREPARA  = 4'd1,
        TRIGGER  = 4'd2,
        ESPERA   = 4'd3,
        MEDE     = 4'd4,
        ARMAZENA = 4'd5,
        FINAL    = 4'd6,
        TIMEOUT  = 4'd7
    } state_t;

    // Decimal increment with carry between digits; sticks at all nines instead of wrapping.
    function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        if (v != ALL_NINES) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic          echo_s1_q, echo_s2_q, echo_prev_q;
    logic          echo_rise, echo_fall;
    logic [TW-1:0] trig_cnt_q, trig_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [EW-1:0] echo_cnt_q, echo_cnt_d;
    logic [RW-1:0] tick_q, tick_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic [BW-1:0] dist_q, dist_d;
    logic [BW-1:0] timeout_dist;
    logic          timeout_q, timeout_d;
    logic          trigger_q;

    // Both edges come from the same delayed pair, so rise and fall share one latency.
    assign echo_rise = echo_s2_q & ~echo_prev_q;
    assign echo_fall = ~echo_s2_q & echo_prev_q;

`ifdef HCSR04_HOLD_LAST_EN
    assign timeout_dist = dist_q;
`else
    assign timeout_dist = ALL_NINES;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        trig_cnt_d = trig_cnt_q;
        wait_cnt_d = wait_cnt_q;
        echo_cnt_d = echo_cnt_q;
        tick_d     = tick_q;
        bcd_d      = bcd_q;
        dist_d     = dist_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            IDLE: if (medir) state_d = PREPARA;
            PREPARA: begin
                trig_cnt_d = '0;
                wait_cnt_d = '0;
                echo_cnt_d = '0;
                tick_d     = '0;
                bcd_d      = '0;
                timeout_d  = 1'b0;
                state_d    = TRIGGER;
            end
            TRIGGER: begin
                if (trig_cnt_q == TRIG_LAST) state_d = ESPERA;
                else                         trig_cnt_d = trig_cnt_q + TW'(1);
            end
            ESPERA: begin
                if (echo_rise) begin
                    state_d = MEDE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = TIMEOUT;
                    timeout_d = 1'b1;
                    dist_d    = timeout_dist;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            MEDE: begin
                // The cycle that sees the fall is still counted, so ticks equal the pin width.
                if (tick_q == R_LAST) begin
                    tick_d = '0;
                    bcd_d  = bcd_inc(bcd_q);
                end else begin
                    tick_d = tick_q + RW'(1);
                end
                if (echo_fall) begin
                    state_d = ARMAZENA;
                end else if (echo_cnt_q == ECHO_LAST) begin
                    state_d   = TIMEOUT;
                    timeout_d = 1'b1;
                    dist_d    = timeout_dist;
                end else begin
                    echo_cnt_d = echo_cnt_q + EW'(1);
                end
            end
            ARMAZENA: begin
                dist_d  = (tick_q >= R_HALF) ? bcd_inc(bcd_q) : bcd_q;
                state_d = FINAL;
            end
            FINAL:   state_d = IDLE;
            TIMEOUT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            echo_s1_q   <= 1'b0;
            echo_s2_q   <= 1'b0;
            echo_prev_q <= 1'b0;
            trig_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            echo_cnt_q  <= '0;
            tick_q      <= '0;
            bcd_q       <= '0;
            dist_q      <= '0;
            timeout_q   <= 1'b0;
            trigger_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            echo_s1_q   <= echo;
            echo_s2_q   <= echo_s1_q;
            echo_prev_q <= echo_s2_q;
            trig_cnt_q  <= trig_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            echo_cnt_q  <= echo_cnt_d;
            tick_q      <= tick_d;
            bcd_q       <= bcd_d;
            dist_q      <= dist_d;
            timeout_q   <= timeout_d;
            trigger_q   <= (state_d == TRIGGER);
        end
    end

    assign trigger   = trigger_q;
    assign pronto    = (state_q == FINAL) || (state_q == TIMEOUT);
    assign timeout   = timeout_q;
    assign distancia = dist_q;
    assign db_estado = state_q;

endmodule

// File: tb/tb_hcsr04_interface_param.sv
// Bench for hcsr04_interface_param: scaled-down timing, measurement-level model checked every cycle,
// plus literal results at each pronto and a 2-digit instance for saturation.
module tb_hcsr04_interface_param;

    localparam int TRIG = 5;
    localparam int RR   = 10;
    localparam int WMAX = 100;
    localparam int EMAX = 2000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        medir = 1'b0;
    logic        echo  = 1'b0;
    logic        trigger, pronto, timeout;
    logic [11:0] distancia;
    logic [3:0]  db_estado;

    logic        medir_b = 1'b0;
    logic        echo_b  = 1'b0;
    logic        trigger_b, pronto_b, timeout_b;
    logic [7:0]  dist_b;
    logic [3:0]  state_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model of the measurement in flight: acceptance cycle, pronto cycle and its result.
    int          acc_cyc = -1000;
    int          pr_cyc  = -1000;
    logic        pr_to   = 1'b0;
    logic [11:0] pr_dist = '0;
    logic [11:0] exp_dist = '0;
    logic        exp_to   = 1'b0;
    bit          cmp_en   = 1'b0;

    hcsr04_interface_param #(
        .TRIG_CLKS(TRIG), .R(RR), .DIGITS(3), .WAIT_MAX(WMAX), .ECHO_MAX(EMAX)
    ) dut (
        .clock(clock), .reset(reset), .medir(medir), .echo(echo),
        .trigger(trigger), .pronto(pronto), .timeout(timeout),
        .distancia(distancia), .db_estado(db_estado)
    );

    hcsr04_interface_param #(
        .TRIG_CLKS(TRIG), .R(RR), .DIGITS(2), .WAIT_MAX(WMAX), .ECHO_MAX(3000)
    ) dut_b (
        .clock(clock), .reset(reset), .medir(medir_b), .echo(echo_b),
        .trigger(trigger_b), .pronto(pronto_b), .timeout(timeout_b),
        .distancia(dist_b), .db_estado(state_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Rounded, saturated centimetre count for a pin width in clocks.
    function automatic int range_cm(input int width, input int digits);
        int cm;
        int maxv;
        cm   = width / RR;
        maxv = 10 ** digits - 1;
        if ((width % RR) >= RR / 2) cm++;
        if (cm > maxv) cm = maxv;
        return cm;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int          x;
        x = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] timeout_dist();
`ifdef HCSR04_HOLD_LAST_EN
        return exp_dist;
`else
        return 12'h999;
`endif
    endfunction

    // Outputs settle after the rising edge; comparing on the falling edge keeps clear of it.
    always @(negedge clock) begin
        if (cmp_en) begin
            if (reset) begin
                exp_dist = '0;
                exp_to   = 1'b0;
            end
            if (cyc == pr_cyc) begin
                exp_dist = pr_dist;
                exp_to   = pr_to;
            end
            if (cyc == acc_cyc + 1) exp_to = 1'b0;
            check("trigger", 32'(trigger), 32'(cyc > acc_cyc && cyc <= acc_cyc + TRIG));
            check("pronto", 32'(pronto), 32'(cyc == pr_cyc));
            check("timeout", 32'(timeout), 32'(exp_to));
            check("distancia", 32'(distancia), 32'(exp_dist));
            if (cyc < acc_cyc || cyc > pr_cyc) check("state_idle", 32'(db_estado), 32'd0);
            else if (cyc == acc_cyc)           check("state_prepara", 32'(db_estado), 32'd1);
            else if (cyc == pr_cyc)            check("state_end", 32'(db_estado), pr_to ? 32'd7 : 32'd6);
            else if (cyc <= acc_cyc + TRIG)    check("state_trigger", 32'(db_estado), 32'd2);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start_meas();
        medir   = 1'b1;
        acc_cyc = cyc + 1;
        pr_cyc  = 1 << 30;
        step(1);
        medir = 1'b0;
    endtask

    task automatic pronto_literal(input string name, input logic [11:0] lit, input logic to_lit);
        check({name, "_pronto"}, 32'(pronto), 32'd1);
        check({name, "_dist"}, 32'(distancia), 32'(lit));
        check({name, "_timeout"}, 32'(timeout), 32'(to_lit));
    endtask

    // width < 0: no echo at all. poke: extra medir pulse in the middle of the echo.
    task automatic measure(input string name, input int delay, input int width, input bit poke,
                           input logic [11:0] lit, input logic to_lit);
        int trig_fall;
        int k_r;
        start_meas();
        trig_fall = acc_cyc + 1 + TRIG;
        if (width < 0) begin
            pr_cyc  = trig_fall + WMAX;
            pr_to   = 1'b1;
            pr_dist = timeout_dist();
            while (cyc < pr_cyc) step(1);
            pronto_literal(name, lit, to_lit);
        end else begin
            step(trig_fall + delay - cyc);
            echo = 1'b1;
            k_r  = cyc;
            if (width <= EMAX) begin
                pr_cyc  = k_r + width + 4;
                pr_to   = 1'b0;
                pr_dist = to_bcd(range_cm(width, 3));
            end else begin
                pr_cyc  = k_r + 3 + EMAX;
                pr_to   = 1'b1;
                pr_dist = timeout_dist();
            end
            while (cyc < pr_cyc || echo) begin
                step(1);
                if (cyc == k_r + width) echo = 1'b0;
                medir = poke && (cyc == k_r + width / 2);
                if (cyc == pr_cyc) pronto_literal(name, lit, to_lit);
            end
            medir = 1'b0;
        end
        step(3);
    endtask

    task automatic measure_b(input string name, input int width, input logic [7:0] lit);
        int n;
        int hi;
        medir_b = 1'b1;
        step(1);
        medir_b = 1'b0;
        n = 0;
        while (!trigger_b && n < 20) begin step(1); n++; end
        hi = 0;
        while (trigger_b && hi < 50) begin step(1); hi++; end
        check({name, "_trigger_width"}, 32'(hi), 32'(TRIG));
        step(2);
        echo_b = 1'b1;
        step(width);
        echo_b = 1'b0;
        n = 0;
        while (!pronto_b && n < 20) begin step(1); n++; end
        check({name, "_pronto"}, 32'(pronto_b), 32'd1);
        check({name, "_dist"}, 32'(dist_b), 32'(lit));
        check({name, "_timeout"}, 32'(timeout_b), 32'd0);
        step(3);
    endtask

`ifdef HCSR04_HOLD_LAST_EN
    localparam logic [11:0] LIT_WAIT_TO = 12'h035;
    localparam logic [11:0] LIT_ECHO_TO = 12'h200;
    localparam logic [11:0] LIT_STUCK   = 12'h042;
`else
    localparam logic [11:0] LIT_WAIT_TO = 12'h999;
    localparam logic [11:0] LIT_ECHO_TO = 12'h999;
    localparam logic [11:0] LIT_STUCK   = 12'h999;
`endif

    initial begin
        step(3);
        check("rst_trigger", 32'(trigger), 32'd0);
        check("rst_pronto", 32'(pronto), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_dist", 32'(distancia), 32'd0);
        check("rst_state", 32'(db_estado), 32'd0);
        reset = 1'b0;
        step(2);
        cmp_en = 1'b1;

        measure("w350", 3, 350, 1'b0, 12'h035, 1'b0);
        measure("w355", 3, 355, 1'b0, 12'h036, 1'b0);
        measure("w354", 3, 354, 1'b0, 12'h035, 1'b0);
        measure("no_echo", 0, -1, 1'b0, LIT_WAIT_TO, 1'b1);
        measure("w_emax", 2, EMAX, 1'b0, 12'h200, 1'b0);
        measure("w_over", 2, EMAX + 1, 1'b0, LIT_ECHO_TO, 1'b1);
        measure("poke", 3, 421, 1'b1, 12'h042, 1'b0);

        // Echo high before ESPERA, then a fall in ESPERA with no rise: must time out.
        start_meas();
        step(1);
        echo    = 1'b1;
        pr_cyc  = acc_cyc + 1 + TRIG + WMAX;
        pr_to   = 1'b1;
        pr_dist = timeout_dist();
        step(acc_cyc + 1 + TRIG + 10 - cyc);
        echo = 1'b0;
        step(pr_cyc - cyc);
        pronto_literal("stuck", LIT_STUCK, 1'b1);
        step(3);

        // Reset in the middle of the trigger pulse.
        start_meas();
        step(2);
        check("pre_reset_trigger", 32'(trigger), 32'd1);
        reset   = 1'b1;
        acc_cyc = -1000;
        pr_cyc  = -1000;
        #1;
        check("async_trigger", 32'(trigger), 32'd0);
        check("async_state", 32'(db_estado), 32'd0);
        check("async_dist", 32'(distancia), 32'd0);
        check("async_pronto", 32'(pronto), 32'd0);
        step(2);
        reset = 1'b0;
        step(10);

        measure("after_rst", 5, 123, 1'b0, 12'h012, 1'b0);

        measure_b("b_sat", 150 * RR, 8'h99);
        measure_b("b_round_sat", 99 * RR + 5, 8'h99);
        measure_b("b_w994", 99 * RR + 4, 8'h99);
        measure_b("b_w124", 12 * RR + 4, 8'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
